dmem_port_arbiter: RTL and testbench
====================================

// Module: dmem_port_arbiter
// PURPOSE
//  Shares the single-port data memory between two requesters: port 0 = pipeline MEM stage,
//  port 1 = debug/loader. At most one access is issued per cycle. Port 0 has priority, and a
//  starvation guard ensures that port 1 is always served eventually. Read data is returned
//  one cycle after the grant, from a registered response.
// PARAMETERS
//  AW        32  address width (the memory decodes addr[4:0])
//  DW        32  data width
//  MAX_WAIT  4   consecutive cycles port 1 may be denied before it is forced a grant (>=1)
// PORTS
//  clk           in   1   clock, rising edge
//  reset         in   1   synchronous, active-high
//  p0_valid      in   1   port 0 request
//  p0_we         in   1   port 0: 1 = write, 0 = read
//  p0_addr       in   AW  port 0 address
//  p0_wdata      in   DW  port 0 write data
//  p0_ready      out  1   port 0 granted this cycle (combinational)
//  p0_rvalid     out  1   port 0 read data valid (registered)
//  p0_rdata      out  DW  port 0 read data
//  p1_*          same set as p0_* for port 1
//  mem_wr        out  1   to memory wr
//  mem_rd        out  1   to memory rd
//  mem_addr      out  AW  to memory addr
//  mem_wdata     out  DW  to memory data_in
//  mem_rdata     in   DW  from memory data_out (combinational read)
// BEHAVIOUR
//  - Grant/handshake: a request transfers when valid && ready. A requester holds valid and all
//    of its fields stable until ready. ready is never asserted without valid.
//  - FSM, 2 states:
//      S_NORM   grant p0 if p0_valid, else grant p1 if p1_valid.
//      S_FORCE  grant p1 if p1_valid, else fall back to p0.
//    S_NORM -> S_FORCE when p1_valid is denied and wait_cnt == MAX_WAIT-1.
//    S_FORCE -> S_NORM after one cycle, always.
//  - wait_cnt: clears on any p1 grant, or when p1_valid is low. Increments, saturating at
//    MAX_WAIT-1, when p1_valid is denied. Width is $clog2(MAX_WAIT+1).
//  - Memory drive in the grant cycle:
//      mem_addr/mem_wdata = granted port's fields
//      mem_wr = we
//      mem_rd = ~we
//      no grant -> mem_wr = mem_rd = 0; addr/wdata hold the port-0 fields.
//  - Write: memory updates at the grant clock edge. rvalid is not raised.
//  - Read: at the grant edge, mem_rdata is captured into the granted port's rdata reg.
//    pX_rvalid = 1 for exactly the next cycle.
//    pX_rdata holds its last value while rvalid = 0.
//  - Back-to-back grants are allowed every cycle. Read-after-write to the same address in the
//    following cycle returns the new data.
//  - Reset (also mid-operation):
//      state = S_NORM, wait_cnt = 0
//      p0/p1_rvalid = 0, p0/p1_rdata = 0
//      ready outputs = 0 while reset is high
//      mem_wr = mem_rd = 0 while reset is high
//    A pending read response is discarded.
// CONFIGURATION
//  DMEM_ARB_STATS_EN defined:
//    Adds outputs p0_grant_cnt[15:0], p1_grant_cnt[15:0] and force_cnt[15:0]. These are
//    saturating counters of grants and S_FORCE entries, cleared by reset.
//  DMEM_ARB_STATS_EN undefined:
//    Those ports and counters do not exist. Arbitration behaviour is identical.
// STRUCTURE
//  - Shared package dmem_arb_pkg:
//      state enum (S_NORM, S_FORCE)
//      port index localparams P_CPU = 0, P_DBG = 1
//      default MAX_WAIT
//  - One sub-module, dmem_arb_resp_reg: per-port registered rvalid/rdata capture,
//    instantiated twice.
//  - Arbitration FSM and memory mux sit in the top module.
// TESTING
//  1. Reset mid-read: p0 read granted, reset asserted the next cycle
//       -> p0_rvalid = 0, rdata = 0, state = S_NORM.
//  2. p0 write addr 8 = 0x55, then p0 read addr 8
//       -> second cycle: ready = 1; third cycle: p0_rvalid = 1, p0_rdata = 0x55.
//  3. p0 and p1 both valid continuously, MAX_WAIT = 4
//       -> p1 is granted on cycle 5 only, then every 5th cycle; p0 gets the rest.
//  4. p1 alone, reading addr 0, 12 on consecutive cycles
//       -> back-to-back ready, p1_rdata = 100 then 0xBB one cycle after each grant.
//  5. S_FORCE entered with p1_valid dropped
//       -> p0 granted in that cycle, return to S_NORM, wait_cnt = 0.
//  6. With DMEM_ARB_STATS_EN: run scenario 3 for 20 cycles
//       -> p0_grant_cnt = 16, p1_grant_cnt = 4, force_cnt = 4.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg
// Shared definitions for the data-memory port arbiter:
//   - arb_state_e     : arbitration FSM states
//   - P_CPU / P_DBG   : requester port indices (pipeline MEM stage / debug-loader)
//   - MAX_WAIT_DEFAULT: default starvation limit for the debug port
//   - sat_inc16       : saturating 16-bit increment used by the optional statistics
//                       counters (DMEM_ARB_STATS_EN)
package dmem_arb_pkg;

    typedef enum logic {
        S_NORM  = 1'b0,
        S_FORCE = 1'b1
    } arb_state_e;

    localparam int P_CPU = 0;
    localparam int P_DBG = 1;

    localparam int MAX_WAIT_DEFAULT = 4;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v, input logic en);
        if (en && (v != 16'hFFFF)) begin
            return v + 16'd1;
        end
        return v;
    endfunction

endpackage

// File: rtl/dmem_arb_if.sv
// dmem_arb_if
// Bus bundles for the data-memory arbiter.
//   dmem_port_if : one requester port
//     valid/we/addr/wdata : request (held stable by the requester until ready)
//     ready               : grant this cycle (combinational)
//     rvalid/rdata        : registered read response, one cycle after a read grant
//     modports: master = requester, slave = arbiter
//   dmem_mem_if  : single-port memory side
//     wr/rd/addr/wdata    : access issued by the arbiter
//     rdata               : combinational read data from the memory
//     modports: master = arbiter, slave = memory
interface dmem_port_if
    import dmem_arb_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          valid;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          ready;
    logic          rvalid;
    logic [DW-1:0] rdata;

    modport master (output valid, we, addr, wdata, input ready, rvalid, rdata);
    modport slave  (input valid, we, addr, wdata, output ready, rvalid, rdata);
endinterface

interface dmem_mem_if
    import dmem_arb_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          wr;
    logic          rd;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;

    modport master (output wr, rd, addr, wdata, input rdata);
    modport slave  (input wr, rd, addr, wdata, output rdata);
endinterface

// File: rtl/dmem_arb_resp_reg.sv
// dmem_arb_resp_reg
// Registered read response for one requester port. When cap is high at a clock edge
// the memory read data is captured and rvalid is raised for exactly the next cycle;
// otherwise rdata holds its last value. Reset clears both, discarding any pending response.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   cap         : read grant to this port in the current cycle
//   mem_rdata   : combinational memory read data
//   rvalid      : response valid (registered)
//   rdata       : response data (registered)
module dmem_arb_resp_reg
    import dmem_arb_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cap,
    input  logic [DW-1:0] mem_rdata,
    output logic          rvalid,
    output logic [DW-1:0] rdata
);

    logic          rvalid_d, rvalid_q;
    logic [DW-1:0] rdata_d,  rdata_q;

    always_comb begin
        rvalid_d = cap;
        rdata_d  = rdata_q;
        if (cap) begin
            rdata_d = mem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    assign rvalid = rvalid_q;
    assign rdata  = rdata_q;

endmodule

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
// Shares a single-port data memory between the pipeline MEM stage (p0, priority) and the
// debug/loader port (p1). At most one access per cycle. A starvation guard forces a p1
// grant after MAX_WAIT consecutive denied cycles. Read data returns one cycle after the
// grant from a per-port registered response.
// Ports:
//   clk, reset : clock (rising edge), synchronous active-high reset
//   p0, p1     : requester ports (dmem_port_if.slave)
//   mem        : memory side (dmem_mem_if.master)
// Optional feature, macro DMEM_ARB_STATS_EN:
//   adds p0_grant_cnt, p1_grant_cnt, force_cnt (16-bit saturating, cleared by reset).
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    dmem_port_if.slave  p0,
    dmem_port_if.slave  p1,
    dmem_mem_if.master  mem
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [15:0] p0_grant_cnt,
    output logic [15:0] p1_grant_cnt,
    output logic [15:0] force_cnt
`endif
);

    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(MAX_WAIT - 1);

    arb_state_e    state_d, state_q;
    logic [CW-1:0] wait_cnt_d, wait_cnt_q;
    logic [1:0]    gnt;
    logic          p1_denied;
    logic          gnt_we;
    logic [AW-1:0] addr_mux;
    logic [DW-1:0] wdata_mux;

    // Grant decision, next state and starvation counter
    always_comb begin
        gnt        = 2'b00;
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;

        // Nothing is granted while reset is held, so ready and mem strobes stay low.
        if (!reset) begin
            case (state_q)
                S_FORCE: begin
                    if (p1.valid)      gnt[P_DBG] = 1'b1;
                    else if (p0.valid) gnt[P_CPU] = 1'b1;
                end
                default: begin
                    if (p0.valid)      gnt[P_CPU] = 1'b1;
                    else if (p1.valid) gnt[P_DBG] = 1'b1;
                end
            endcase
        end

        p1_denied = p1.valid && !gnt[P_DBG];

        case (state_q)
            S_FORCE: state_d = S_NORM;
            default: begin
                if (p1_denied && (wait_cnt_q == WAIT_LAST)) state_d = S_FORCE;
            end
        endcase

        if (gnt[P_DBG] || !p1.valid) begin
            wait_cnt_d = '0;
        end else if (p1_denied && (wait_cnt_q != WAIT_LAST)) begin
            wait_cnt_d = wait_cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_NORM;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Memory mux: with no grant the address/data lines simply follow port 0.
    always_comb begin
        addr_mux  = p0.addr;
        wdata_mux = p0.wdata;
        gnt_we    = p0.we;
        if (gnt[P_DBG]) begin
            addr_mux  = p1.addr;
            wdata_mux = p1.wdata;
            gnt_we    = p1.we;
        end
    end

    assign mem.addr  = addr_mux;
    assign mem.wdata = wdata_mux;
    assign mem.wr    = (|gnt) &&  gnt_we;
    assign mem.rd    = (|gnt) && !gnt_we;

    assign p0.ready  = gnt[P_CPU];
    assign p1.ready  = gnt[P_DBG];

    dmem_arb_resp_reg #(.DW(DW)) u_resp_p0 (
        .clk       (clk),
        .reset     (reset),
        .cap       (gnt[P_CPU] && !p0.we),
        .mem_rdata (mem.rdata),
        .rvalid    (p0.rvalid),
        .rdata     (p0.rdata)
    );

    dmem_arb_resp_reg #(.DW(DW)) u_resp_p1 (
        .clk       (clk),
        .reset     (reset),
        .cap       (gnt[P_DBG] && !p1.we),
        .mem_rdata (mem.rdata),
        .rvalid    (p1.rvalid),
        .rdata     (p1.rdata)
    );

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] p0_cnt_d, p0_cnt_q;
    logic [15:0] p1_cnt_d, p1_cnt_q;
    logic [15:0] frc_cnt_d, frc_cnt_q;

    always_comb begin
        p0_cnt_d  = sat_inc16(p0_cnt_q, gnt[P_CPU]);
        p1_cnt_d  = sat_inc16(p1_cnt_q, gnt[P_DBG]);
        frc_cnt_d = sat_inc16(frc_cnt_q, (state_q == S_NORM) && (state_d == S_FORCE));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            p0_cnt_q  <= '0;
            p1_cnt_q  <= '0;
            frc_cnt_q <= '0;
        end else begin
            p0_cnt_q  <= p0_cnt_d;
            p1_cnt_q  <= p1_cnt_d;
            frc_cnt_q <= frc_cnt_d;
        end
    end

    assign p0_grant_cnt = p0_cnt_q;
    assign p1_grant_cnt = p1_cnt_q;
    assign force_cnt    = frc_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
module tb_dmem_port_arbiter;
    import dmem_arb_pkg::*;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    dmem_port_if #(.AW(32), .DW(32)) p0_if ();
    dmem_port_if #(.AW(32), .DW(32)) p1_if ();
    dmem_mem_if  #(.AW(32), .DW(32)) mem_if ();

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] p0_grant_cnt, p1_grant_cnt, force_cnt;
`endif

    dmem_port_arbiter #(.AW(32), .DW(32), .MAX_WAIT(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .p0           (p0_if.slave),
        .p1           (p1_if.slave),
        .mem          (mem_if.master)
`ifdef DMEM_ARB_STATS_EN
        ,
        .p0_grant_cnt (p0_grant_cnt),
        .p1_grant_cnt (p1_grant_cnt),
        .force_cnt    (force_cnt)
`endif
    );

    // 32-word memory model, combinational read, write at the clock edge
    logic [31:0] mem_arr [32];
    assign mem_if.rdata = mem_arr[mem_if.addr[4:0]];
    always @(posedge clk) begin
        if (mem_if.wr) mem_arr[mem_if.addr[4:0]] <= mem_if.wdata;
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv0(input logic v, input logic we, input logic [31:0] a, input logic [31:0] d);
        p0_if.valid = v; p0_if.we = we; p0_if.addr = a; p0_if.wdata = d;
    endtask

    task automatic drv1(input logic v, input logic we, input logic [31:0] a, input logic [31:0] d);
        p1_if.valid = v; p1_if.we = we; p1_if.addr = a; p1_if.wdata = d;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        drv0(1'b0, 1'b0, 32'd0, 32'd0);
        drv1(1'b0, 1'b0, 32'd0, 32'd0);

        // Reset state, requests present while reset is held
        tick(); tick();
        drv0(1'b1, 1'b0, 32'd3, 32'd0);
        drv1(1'b1, 1'b1, 32'd5, 32'd7);
        #2;
        chk("rst_p0_ready", 32'(p0_if.ready), 32'd0);
        chk("rst_p1_ready", 32'(p1_if.ready), 32'd0);
        chk("rst_mem_rd", 32'(mem_if.rd), 32'd0);
        chk("rst_mem_wr", 32'(mem_if.wr), 32'd0);
        chk("rst_p0_rvalid", 32'(p0_if.rvalid), 32'd0);
        chk("rst_p0_rdata", p0_if.rdata, 32'd0);
        chk("rst_state", 32'(dut.state_q), 32'(S_NORM));

        // p0 write addr 8 = 0x55, then read it back
        tick();
        reset = 1'b0;
        drv1(1'b0, 1'b0, 32'd0, 32'd0);
        drv0(1'b1, 1'b1, 32'd8, 32'h55);
        #2;
        chk("wr_p0_ready", 32'(p0_if.ready), 32'd1);
        chk("wr_mem_wr", 32'(mem_if.wr), 32'd1);
        chk("wr_mem_rd", 32'(mem_if.rd), 32'd0);
        chk("wr_mem_addr", mem_if.addr, 32'd8);
        chk("wr_mem_wdata", mem_if.wdata, 32'h55);
        tick();
        drv0(1'b1, 1'b0, 32'd8, 32'd0);
        #2;
        chk("rd_p0_ready", 32'(p0_if.ready), 32'd1);
        chk("rd_mem_rd", 32'(mem_if.rd), 32'd1);
        chk("wr_no_rvalid", 32'(p0_if.rvalid), 32'd0);
        tick();
        drv0(1'b0, 1'b0, 32'd20, 32'h1234);
        #2;
        chk("raw_p0_rvalid", 32'(p0_if.rvalid), 32'd1);
        chk("raw_p0_rdata", p0_if.rdata, 32'h55);
        chk("idle_mem_addr", mem_if.addr, 32'd20);
        chk("idle_mem_wdata", mem_if.wdata, 32'h1234);
        chk("idle_mem_wr", 32'(mem_if.wr), 32'd0);
        chk("idle_mem_rd", 32'(mem_if.rd), 32'd0);
        tick();
        #2;
        chk("hold_p0_rvalid", 32'(p0_if.rvalid), 32'd0);
        chk("hold_p0_rdata", p0_if.rdata, 32'h55);

        // Reset mid-read
        tick();
        drv0(1'b1, 1'b0, 32'd8, 32'd0);
        #2;
        chk("mid_p0_ready", 32'(p0_if.ready), 32'd1);
        tick();
        reset = 1'b1;
        drv0(1'b0, 1'b0, 32'd0, 32'd0);
        tick();
        reset = 1'b0;
        #2;
        chk("mid_rst_rvalid", 32'(p0_if.rvalid), 32'd0);
        chk("mid_rst_rdata", p0_if.rdata, 32'd0);
        chk("mid_rst_state", 32'(dut.state_q), 32'(S_NORM));

        // p1 alone: load addr 0 = 100, addr 12 = 0xBB, then read both back-to-back
        tick();
        drv1(1'b1, 1'b1, 32'd0, 32'd100);
        #2;
        chk("p1_wr0_ready", 32'(p1_if.ready), 32'd1);
        chk("p1_wr0_mem_wr", 32'(mem_if.wr), 32'd1);
        chk("p1_wr0_addr", mem_if.addr, 32'd0);
        tick();
        drv1(1'b1, 1'b1, 32'd12, 32'hBB);
        #2;
        chk("p1_wr12_ready", 32'(p1_if.ready), 32'd1);
        chk("p1_wr12_wdata", mem_if.wdata, 32'hBB);
        tick();
        drv1(1'b1, 1'b0, 32'd0, 32'd0);
        #2;
        chk("p1_rd0_ready", 32'(p1_if.ready), 32'd1);
        chk("p1_rd0_mem_rd", 32'(mem_if.rd), 32'd1);
        tick();
        drv1(1'b1, 1'b0, 32'd12, 32'd0);
        #2;
        chk("p1_rd12_ready", 32'(p1_if.ready), 32'd1);
        chk("p1_rd0_rvalid", 32'(p1_if.rvalid), 32'd1);
        chk("p1_rd0_rdata", p1_if.rdata, 32'd100);
        tick();
        drv1(1'b0, 1'b0, 32'd0, 32'd0);
        #2;
        chk("p1_rd12_rvalid", 32'(p1_if.rvalid), 32'd1);
        chk("p1_rd12_rdata", p1_if.rdata, 32'hBB);
        chk("p1_only_p0_rvalid", 32'(p0_if.rvalid), 32'd0);

        // Both ports continuously valid: p1 wins cycles 4, 9, 14, 19 (0-based)
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drv0(1'b1, 1'b0, 32'd8, 32'd0);
        drv1(1'b1, 1'b0, 32'd12, 32'd0);
        for (int i = 0; i < 24; i++) begin
            #2;
            chk($sformatf("both_p1_ready_%0d", i), 32'(p1_if.ready), 32'((i % 5) == 4 && i < 20));
            chk($sformatf("both_p0_ready_%0d", i), 32'(p0_if.ready), 32'(!((i % 5) == 4 && i < 20)));
            chk($sformatf("both_p1_rvalid_%0d", i), 32'(p1_if.rvalid), 32'(i > 0 && ((i - 1) % 5) == 4 && i <= 20));
            if (i == 20) begin
                chk("both_p1_rdata", p1_if.rdata, 32'hBB);
`ifdef DMEM_ARB_STATS_EN
                chk("stats_p0_grant_cnt", 32'(p0_grant_cnt), 32'd16);
                chk("stats_p1_grant_cnt", 32'(p1_grant_cnt), 32'd4);
                chk("stats_force_cnt", 32'(force_cnt), 32'd4);
`endif
            end
            tick();
        end

        // Cycle 24 is S_FORCE; p1 drops its request so p0 takes the slot
        drv1(1'b0, 1'b0, 32'd12, 32'd0);
        #2;
        chk("force_state", 32'(dut.state_q), 32'(S_FORCE));
        chk("force_p0_ready", 32'(p0_if.ready), 32'd1);
        chk("force_p1_ready", 32'(p1_if.ready), 32'd0);
        chk("force_mem_addr", mem_if.addr, 32'd8);
        tick();
        #2;
        chk("after_force_state", 32'(dut.state_q), 32'(S_NORM));
        chk("after_force_wait", 32'(dut.wait_cnt_q), 32'd0);
        chk("after_force_p0_rvalid", 32'(p0_if.rvalid), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish, required finish within 100000 time units");
        $fatal(1, "timeout");
    end

endmodule
